inst_mem_loader: RTL

- Parametrised, synchronous-read instruction memory for the 16-bit MIPS-style core.
- Successor to the combinational, reset-initialised program store: the program is streamed in over a valid/ready load port instead of being hard-coded.
- A FILL phase pads unused words with NOP, and fetch is registered with stall support.
- Sits between the PC/fetch stage and an external boot/test loader.

---
 rtl/inst_mem_pkg.sv | 27 ++
 rtl/inst_mem_array.sv | 31 +++
 rtl/inst_mem_loader.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/inst_mem_pkg.sv
// Shared types and constants for the streamed instruction memory (inst_mem_loader).
// Opcode constants let loaders and benches build realistic program words.
package inst_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FILL = 2'd2,
        RUN  = 2'd3
    } state_t;

    localparam logic [15:0] NOP_INSTR_DEFAULT = 16'b0000010010100000;

    localparam logic [3:0] OP_ADDI = 4'b1001;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b1010;
    localparam logic [3:0] OP_ST   = 4'b1011;

    // Packs a 16-bit instruction as opcode followed by three 4-bit fields.
    function automatic logic [15:0] encode_instr(input logic [3:0] op,
                                                 input logic [3:0] f2,
                                                 input logic [3:0] f1,
                                                 input logic [3:0] f0);
        return {op, f2, f1, f0};
    endfunction

endpackage

// File: rtl/inst_mem_array.sv
// Single write port, single registered read port storage for the instruction memory.
// The read register holds its value whenever no read is requested.
module inst_mem_array #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 64,
    parameter int PTR_W = 6
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/inst_mem_loader.sv
// Streamed-load instruction memory: LOAD over valid/ready, NOP padding in FILL, registered fetch in RUN.
// Optional read parity checking is built when INST_MEM_PARITY_EN is defined.
module inst_mem_loader
    import inst_mem_pkg::*;
#(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 8,
    parameter int                DEPTH     = 64,
    parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(NOP_INSTR_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic              load_last,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              load_done,
    output logic              busy,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] adr,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    output logic              parity_err
);

    localparam int                PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
`ifdef INST_MEM_PARITY_EN
    localparam int                MEM_W     = DATA_W + 1;
`else
    localparam int                MEM_W     = DATA_W;
`endif

    state_t            state;
    state_t            state_next;
    logic [PTR_W-1:0]  wptr;
    logic              beat;
    logic              at_last;
    logic              load_end;
    logic              done_evt;
    logic              fetch_go;
    logic              in_range;
    logic              mem_we;
    logic [DATA_W-1:0] wr_word;
    logic [MEM_W-1:0]  mem_wdata;
    logic [MEM_W-1:0]  mem_rdata;
    logic              nop_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (load_start) begin
                    state_next = LOAD;
                end else if (fetch_en) begin
                    state_next = RUN;
                end
            end
            LOAD: begin
                if (load_end) begin
                    state_next = at_last ? IDLE : FILL;
                end
            end
            FILL: begin
                if (at_last) begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                if (load_start) begin
                    state_next = LOAD;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A restart in LOAD still writes a beat handshaked in that cycle, but the load does not end on it.
    always_comb begin
        load_ready = (state == LOAD);
        busy       = (state == LOAD) || (state == FILL);
        at_last    = (wptr == LAST_PTR);
        beat       = load_ready && load_valid;
        load_end   = beat && !load_start && (load_last || at_last);
        done_evt   = ((state == LOAD) && load_end && at_last) ||
                     ((state == FILL) && at_last);
        fetch_go   = fetch_en && !load_start && ((state == IDLE) || (state == RUN));
        mem_we     = beat || (state == FILL);
        wr_word    = (state == FILL) ? NOP_INSTR : load_data;
        in_range   = ({1'b0, adr} < DEPTH_LIM);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr      <= '0;
            out_valid <= 1'b0;
            nop_q     <= 1'b1;
            load_done <= 1'b0;
        end else begin
            load_done <= done_evt;
            out_valid <= fetch_go;
            if (fetch_go) begin
                nop_q <= !in_range;
            end
            if (load_start && (state != FILL)) begin
                wptr <= '0;
            end else if (mem_we) begin
                wptr <= at_last ? '0 : wptr + 1'b1;
            end
        end
    end

`ifdef INST_MEM_PARITY_EN
    logic par_bad;
    logic par_q;

    assign mem_wdata = {^wr_word, wr_word};

    // Even parity over data plus stored bit must be zero; out-of-range reads carry no stored word.
    always_comb begin
        par_bad    = (^mem_rdata) && !nop_q;
        out        = (nop_q || par_bad) ? NOP_INSTR : mem_rdata[DATA_W-1:0];
        parity_err = par_q || (out_valid && par_bad);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            par_q <= 1'b0;
        end else if (out_valid && par_bad) begin
            par_q <= 1'b1;
        end
    end
`else
    assign mem_wdata = wr_word;

    always_comb begin
        out        = nop_q ? NOP_INSTR : mem_rdata;
        parity_err = 1'b0;
    end
`endif

    inst_mem_array #(
        .WIDTH(MEM_W),
        .DEPTH(DEPTH),
        .PTR_W(PTR_W)
    ) u_array (
        .clk  (clk),
        .we   (mem_we),
        .waddr(wptr),
        .wdata(mem_wdata),
        .re   (fetch_go),
        .raddr(adr[PTR_W-1:0]),
        .rdata(mem_rdata)
    );

endmodule
